trig_data_framer: RTL and testbench
===================================

Name: trig_data_framer

Overview:
Downstream consumer of the dynode trigger block's trigger-data FIFO (16-bit q / ren / ne handshake).
- On each accepted trigger, drains exactly NSAMP samples from that FIFO and frames them into 33-bit words: header, packed body, trailer.
- Writes the words into a downstream 33-bit readout FIFO (fifo33-style d/wen/nearlyfull).
- Control and counters live on the standard 34-bit ibus / 16-bit obus register bus.

Parameters:
BASE, 16'h0040, register-bus base address; block occupies BASE..BASE+4
TIMEOUT, 64, cycles without fifo_ne while samples are still owed before padding is used
DEFNSAMP, 8, power-up value of the NSAMP register

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on next rising clk)
ibus  in  34  {clk, wr, addr[15:0], wrdata[15:0]} register-bus inputs
obus  out  16  register read data; high-Z unless addr in BASE..BASE+4
trigger  in  1  one-cycle event strobe
fifo_q  in  16  trigger-data FIFO output; valid the cycle after fifo_ren
fifo_ne  in  1  trigger-data FIFO not empty
fifo_ren  out  1  trigger-data FIFO read enable
out_d  out  33  framed word to readout FIFO
out_wen  out  1  readout FIFO write enable, one word per cycle high
out_nearlyfull  in  1  readout FIFO backpressure

Behaviour:
Register map:
- BASE+0 CTRL, RW:
  - bit0 ENABLE (PU 0).
  - bit1 CLR: write-1 clears EVCNT and DROPCNT on that cycle; not stored, reads 0.
- BASE+1 NSAMP, RW, 8 bits, PU DEFNSAMP.
- BASE+2 EVCNT, RO, 16 bits, wraps.
- BASE+3 DROPCNT, RO, 16 bits, saturates at FFFF.
- BASE+4 STATUS, RO: [2:0] FSM state, [15:8] samples remaining.
- Register writes take effect on the clk edge where wr && addr match. NSAMP is latched at trigger acceptance; writes mid-frame do not affect the current frame.

Reset (reset==0):
- Outputs: fifo_ren=0, out_wen=0, out_d=0.
- State: FSM->IDLE; EVCNT=0, DROPCNT=0, ENABLE=0, NSAMP=DEFNSAMP, checksum=0.
- Reset mid-frame abandons the frame with no trailer; partial words already written stay in the readout FIFO.

FSM states: IDLE(0), HDR(1), READ(2), PACK(3), TRL(4).
- IDLE:
  - trigger && ENABLE -> HDR; latch nsamp, clear checksum, clear timeout flag.
  - trigger && !ENABLE -> ignored, not counted.
- HDR:
  - If !out_nearlyfull: out_wen=1, out_d={1'b1, 8'hA5, nsamp[7:0], EVCNT}.
  - Then -> READ if nsamp!=0, else -> TRL.
  - First event's header carries EVCNT=0.
- READ:
  - fifo_ren=1 only when fifo_ne && !out_nearlyfull && samples remaining.
  - Sample captured from fifo_q exactly one cycle after fifo_ren.
  - At most one read in flight.
  - Checksum += sample, mod 2^16.
- PACK:
  - Samples pair as {1'b0, first, second}; out_wen pulses when the pair completes.
  - Odd final sample: {1'b0, sample, 16'h0000}.
  - Returns to READ while samples remain, else -> TRL.
- Timeout:
  - Counter increments each READ cycle with !fifo_ne; resets on any read.
  - At TIMEOUT: remaining samples substituted with 16'h0000 without asserting fifo_ren, timeout flag set.
- TRL:
  - If !out_nearlyfull: out_wen=1, out_d={1'b0, 8'h5A, 7'b0, toflag, checksum}.
  - EVCNT increments on the same edge; -> IDLE.
- Drops: trigger in any state other than IDLE, with ENABLE=1, increments DROPCNT.
- Simultaneous CLR write and EVCNT increment: clear wins.
- Backpressure: while out_nearlyfull, no out_wen and no new fifo_ren. A read already issued still completes its capture into the pack register.
- Latency, no backpressure: header on the edge after the trigger edge. One body word per two samples, each sample costing ≥2 cycles (ren then capture). Trailer one cycle after the last body word.

Test Plan:
- ENABLE=1, NSAMP=4, FIFO preloaded 1,2,3,4, trigger -> out words 1_A504_0000, 0_0001_0002, 0_0003_0004, 0_5A00_000A; EVCNT=1; fifo_ren pulsed exactly 4 times.
- NSAMP=3, samples 1,2,3 -> body 0_0001_0002, 0_0003_0000; trailer 0_5A00_0006.
- Second trigger 2 cycles after the first (frame busy) -> DROPCNT=1, one frame only. Trigger with ENABLE=0 -> no output, DROPCNT unchanged.
- NSAMP=4, only samples 5,6 available, TIMEOUT=64 -> 64 empty cycles, then body 0_0005_0006, 0_0000_0000 and trailer 0_5A01_000B.
- out_nearlyfull held high for 20 cycles mid-body -> no out_wen or new fifo_ren during the hold; frame completes identically afterwards.
- reset=0 asserted during READ -> next cycle IDLE, out_wen=0, EVCNT=0; NSAMP=0 frame -> header 1_A500_xxxx then trailer 0_5A00_0000 with no reads.

Source files
------------

// File: rtl/trig_data_framer.sv
// rtl/trig_data_framer.sv - frames trigger-data FIFO samples into 33-bit readout words
// Header, paired-sample body and checksum trailer per accepted trigger; ibus/obus registers.
module trig_data_framer #(
  parameter logic [15:0] BASE     = 16'h0040,
  parameter int          TIMEOUT  = 64,
  parameter logic [7:0]  DEFNSAMP = 8'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [33:0] ibus,
  output logic [15:0] obus,
  input  logic        trigger,
  input  logic [15:0] fifo_q,
  input  logic        fifo_ne,
  output logic        fifo_ren,
  output logic [32:0] out_d,
  output logic        out_wen,
  input  logic        out_nearlyfull
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_READ = 3'd2,
    S_PACK = 3'd3,
    S_TRL  = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state_q;
  logic           enable_q;
  logic [7:0]     nsamp_q;
  logic [7:0]     cur_n_q;
  logic [7:0]     rem_q;
  logic [15:0]    evcnt_q;
  logic [15:0]    dropcnt_q;
  logic [15:0]    csum_q;
  logic [15:0]    hi_q;
  logic           have_hi_q;
  logic           pend_q;
  logic           rd_q;
  logic           to_q;
  logic [31:0]    word_q;
  logic [TW-1:0]  to_cnt_q;
  logic [32:0]    out_d_q;
  logic           out_wen_q;

  logic           wr;
  logic [15:0]    addr;
  logic [15:0]    reg_off;
  logic           reg_hit;
  logic           clr;
  logic [15:0]    rd_data;
  logic [15:0]    pack_s;
  logic [31:0]    pack_w;
  logic           unused_ibus;

  assign wr          = ibus[32];
  assign addr        = ibus[31:16];
  assign reg_off     = addr - BASE;
  assign reg_hit     = reg_off < 16'd5;
  assign clr         = wr && reg_hit && (reg_off == 16'd0) && ibus[1];
  assign unused_ibus = ^{ibus[33], ibus[15:8]};

  always_comb begin
    rd_data = 16'h0000;
    case (reg_off)
      16'd0:   rd_data = {15'b0, enable_q};
      16'd1:   rd_data = {8'b0, nsamp_q};
      16'd2:   rd_data = evcnt_q;
      16'd3:   rd_data = dropcnt_q;
      16'd4:   rd_data = {rem_q, 5'b0, state_q};
      default: rd_data = 16'h0000;
    endcase
  end

  assign obus = reg_hit ? rd_data : 16'hzzzz;

  // rem_q counts samples not yet requested, so a zero here means the frame body is fully issued
  assign fifo_ren = (state_q == S_READ) && fifo_ne && !out_nearlyfull &&
                    (rem_q != 8'd0) && !to_q;
  assign pack_s   = rd_q ? fifo_q : 16'h0000;
  assign pack_w   = have_hi_q ? {hi_q, pack_s} : {pack_s, 16'h0000};
  assign out_d    = out_d_q;
  assign out_wen  = out_wen_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      nsamp_q   <= DEFNSAMP;
      cur_n_q   <= 8'd0;
      rem_q     <= 8'd0;
      evcnt_q   <= 16'd0;
      dropcnt_q <= 16'd0;
      csum_q    <= 16'd0;
      hi_q      <= 16'd0;
      have_hi_q <= 1'b0;
      pend_q    <= 1'b0;
      rd_q      <= 1'b0;
      to_q      <= 1'b0;
      word_q    <= 32'd0;
      to_cnt_q  <= '0;
      out_d_q   <= 33'd0;
      out_wen_q <= 1'b0;
    end else begin
      out_wen_q <= 1'b0;
      if (wr && reg_hit && reg_off == 16'd0) enable_q <= ibus[0];
      if (wr && reg_hit && reg_off == 16'd1) nsamp_q <= ibus[7:0];
      if (clr) dropcnt_q <= 16'd0;
      else if (trigger && enable_q && state_q != S_IDLE && dropcnt_q != 16'hFFFF)
        dropcnt_q <= dropcnt_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          if (trigger && enable_q) begin
            state_q   <= S_HDR;
            cur_n_q   <= nsamp_q;
            rem_q     <= nsamp_q;
            csum_q    <= 16'd0;
            to_q      <= 1'b0;
            to_cnt_q  <= '0;
            have_hi_q <= 1'b0;
            pend_q    <= 1'b0;
            rd_q      <= 1'b0;
          end
        end
        S_HDR: begin
          if (!out_nearlyfull) begin
            out_wen_q <= 1'b1;
            out_d_q   <= {1'b1, 8'hA5, cur_n_q, evcnt_q};
            state_q   <= (cur_n_q != 8'd0) ? S_READ : S_TRL;
          end
        end
        S_READ: begin
          if (pend_q && !out_nearlyfull) begin
            out_wen_q <= 1'b1;
            out_d_q   <= {1'b0, word_q};
            pend_q    <= 1'b0;
          end
          if (rem_q == 8'd0) begin
            if (!pend_q || !out_nearlyfull) state_q <= S_TRL;
          end else if (fifo_ren) begin
            rem_q    <= rem_q - 8'd1;
            rd_q     <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= S_PACK;
          end else if (to_q && !out_nearlyfull) begin
            rem_q   <= rem_q - 8'd1;
            rd_q    <= 1'b0;
            state_q <= S_PACK;
          end else if (!fifo_ne && !to_q) begin
            to_cnt_q <= to_cnt_q + TW'(1);
            if (to_cnt_q == TW'(TIMEOUT - 1)) to_q <= 1'b1;
          end
        end
        S_PACK: begin
          csum_q <= csum_q + pack_s;
          if (!have_hi_q && rem_q != 8'd0) begin
            hi_q      <= pack_s;
            have_hi_q <= 1'b1;
            state_q   <= S_READ;
          end else begin
            have_hi_q <= 1'b0;
            // a capture is never lost to backpressure; the finished word waits in word_q
            if (!out_nearlyfull) begin
              out_wen_q <= 1'b1;
              out_d_q   <= {1'b0, pack_w};
              state_q   <= (rem_q == 8'd0) ? S_TRL : S_READ;
            end else begin
              pend_q  <= 1'b1;
              word_q  <= pack_w;
              state_q <= S_READ;
            end
          end
        end
        S_TRL: begin
          if (!out_nearlyfull) begin
            out_wen_q <= 1'b1;
            out_d_q   <= {1'b0, 8'h5A, 7'b0, to_q, csum_q};
            evcnt_q   <= evcnt_q + 16'd1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (clr) evcnt_q <= 16'd0;
    end
  end
endmodule

// File: tb/tb_trig_data_framer.sv
// tb/tb_trig_data_framer.sv - randomized bench for trig_data_framer against a frame-level model
// Expected words come from literal frames or from a per-frame model built from the sample list.
module tb_trig_data_framer;
  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [32:0] bus_q = 33'd0;
  wire  [33:0] ibus = {clk, bus_q};
  wire  [15:0] obus;
  logic        trigger = 1'b0;
  logic [15:0] fifo_q = 16'd0;
  logic        fifo_ne = 1'b0;
  wire         fifo_ren;
  wire  [32:0] out_d;
  wire         out_wen;
  logic        out_nearlyfull = 1'b0;

  always #5 clk = ~clk;

  trig_data_framer #(.BASE(BASE), .TIMEOUT(64), .DEFNSAMP(8'd8)) dut (
    .clk(clk), .reset(reset), .ibus(ibus), .obus(obus), .trigger(trigger),
    .fifo_q(fifo_q), .fifo_ne(fifo_ne), .fifo_ren(fifo_ren),
    .out_d(out_d), .out_wen(out_wen), .out_nearlyfull(out_nearlyfull)
  );

  int          tests = 0;
  int          fails = 0;
  int          wen_cnt = 0;
  int          ren_cnt = 0;
  int          ev_model = 0;
  logic [15:0] src[$];
  logic [15:0] pend_src[$];
  logic [32:0] exp_q[$];
  logic        slow = 1'b0;
  logic        nf_rand = 1'b0;
  logic        nf_force = 1'b0;
  logic        nf_prev = 1'b0;
  logic [15:0] smp[16];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // trigger-data FIFO: data valid the cycle after ren; samples trickle in from pend_src
  always @(posedge clk) begin
    if (fifo_ren) begin
      ren_cnt = ren_cnt + 1;
      tests++;
      if (src.size() == 0) begin
        fails++;
        $display("FAIL ren_on_empty: got ren=1 want ren=0");
      end else fifo_q <= src.pop_front();
    end
    if (pend_src.size() != 0 && (!slow || $urandom_range(2) == 0))
      src.push_back(pend_src.pop_front());
  end

  always @(negedge clk) fifo_ne = (src.size() != 0);
  always @(posedge clk) nf_prev <= out_nearlyfull;
  always @(posedge clk) begin
    #1;
    out_nearlyfull = nf_rand ? ($urandom_range(3) == 0) : nf_force;
  end

  always @(negedge clk) begin
    if (out_wen) begin
      wen_cnt = wen_cnt + 1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h want none", out_d);
      end else chk("out_word", out_d, exp_q.pop_front());
      chk("wen_vs_nearlyfull", {32'b0, nf_prev}, 33'd0);
    end
    if (fifo_ren) chk("ren_vs_nearlyfull", {32'b0, out_nearlyfull}, 33'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wreg(input logic [15:0] a, input logic [15:0] d);
    tick();
    bus_q = {1'b1, a, d};
    tick();
    bus_q = {1'b0, a, d};
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string name);
    bus_q = {1'b0, a, 16'h0000};
    @(negedge clk);
    chk(name, {17'b0, obus}, {17'b0, e});
  endtask

  task automatic trig();
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic push_samples(input int k);
    for (int i = 0; i < k; i++) pend_src.push_back(smp[i]);
  endtask

  // n samples owed, only the first k of smp[] ever arrive; the rest become zero padding
  task automatic model_frame(input int n, input int k);
    logic [15:0] v[16];
    int sum;
    sum = 0;
    exp_q.push_back({1'b1, 8'hA5, 8'(n), 16'(ev_model)});
    for (int i = 0; i < n; i++) begin
      v[i] = (i < k) ? smp[i] : 16'h0000;
      sum += int'(v[i]);
    end
    for (int i = 0; i < n; i += 2)
      exp_q.push_back({1'b0, v[i], (i + 1 < n) ? v[i + 1] : 16'h0000});
    exp_q.push_back({1'b0, 8'h5A, 7'b0, (k < n), 16'(sum)});
    ev_model++;
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d words pending want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic wait_wen(input int target, output int t);
    t = 0;
    while (wen_cnt < target && t < 500) begin
      tick();
      t++;
    end
    if (wen_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL wen_wait: got %0d words want %0d", wen_cnt, target);
    end
  endtask

  initial begin
    int r0, w0, w1, t, gap, n, k;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_wen", {32'b0, out_wen}, 33'd0);
    chk("rst_fifo_ren", {32'b0, fifo_ren}, 33'd0);
    chk("rst_out_d", out_d, 33'd0);
    reset = 1'b1;
    rd(BASE + 16'd0, 16'h0000, "rst_ctrl");
    rd(BASE + 16'd1, 16'h0008, "rst_nsamp");
    rd(BASE + 16'd2, 16'h0000, "rst_evcnt");
    rd(BASE + 16'd3, 16'h0000, "rst_dropcnt");
    rd(BASE + 16'd4, 16'h0000, "rst_status");

    wreg(BASE, 16'h0001);
    wreg(BASE + 16'd1, 16'd4);
    for (int i = 0; i < 4; i++) smp[i] = 16'(i + 1);
    push_samples(4);
    exp_q.push_back(33'h1_A504_0000);
    exp_q.push_back(33'h0_0001_0002);
    exp_q.push_back(33'h0_0003_0004);
    exp_q.push_back(33'h0_5A00_000A);
    ev_model = 1;
    r0 = ren_cnt;
    trig();
    wait_frame();
    chk("frame4_ren_count", 33'(ren_cnt - r0), 33'd4);
    rd(BASE + 16'd2, 16'h0001, "frame4_evcnt");

    wreg(BASE + 16'd1, 16'd3);
    for (int i = 0; i < 3; i++) smp[i] = 16'(i + 1);
    push_samples(3);
    exp_q.push_back(33'h1_A503_0001);
    exp_q.push_back(33'h0_0001_0002);
    exp_q.push_back(33'h0_0003_0000);
    exp_q.push_back(33'h0_5A00_0006);
    ev_model = 2;
    trig();
    wait_frame();

    wreg(BASE + 16'd1, 16'd2);
    smp[0] = 16'd7;
    smp[1] = 16'd8;
    push_samples(2);
    exp_q.push_back(33'h1_A502_0002);
    exp_q.push_back(33'h0_0007_0008);
    exp_q.push_back(33'h0_5A00_000F);
    ev_model = 3;
    trig();
    trig();
    wait_frame();
    rd(BASE + 16'd3, 16'h0001, "drop_busy");
    rd(BASE + 16'd2, 16'h0003, "drop_evcnt");
    wreg(BASE, 16'h0000);
    w0 = wen_cnt;
    trig();
    repeat (20) tick();
    chk("disabled_no_words", 33'(wen_cnt - w0), 33'd0);
    rd(BASE + 16'd3, 16'h0001, "disabled_dropcnt");

    wreg(BASE, 16'h0003);
    ev_model = 0;
    rd(BASE + 16'd0, 16'h0001, "clr_ctrl");
    rd(BASE + 16'd2, 16'h0000, "clr_evcnt");
    rd(BASE + 16'd3, 16'h0000, "clr_dropcnt");

    wreg(BASE + 16'd1, 16'd4);
    smp[0] = 16'd5;
    smp[1] = 16'd6;
    push_samples(2);
    exp_q.push_back(33'h1_A504_0000);
    exp_q.push_back(33'h0_0005_0006);
    exp_q.push_back(33'h0_0000_0000);
    exp_q.push_back(33'h0_5A01_000B);
    ev_model = 1;
    w0 = wen_cnt;
    trig();
    wait_wen(w0 + 2, t);
    wait_wen(w0 + 3, gap);
    chk("timeout_gap", {32'b0, (gap >= 64 && gap <= 72)}, 33'd1);
    wait_frame();

    wreg(BASE + 16'd1, 16'd6);
    for (int i = 0; i < 6; i++) smp[i] = 16'($urandom);
    push_samples(6);
    model_frame(6, 6);
    w0 = wen_cnt;
    trig();
    wait_wen(w0 + 2, t);
    nf_force = 1'b1;
    @(posedge clk);
    #2;
    r0 = ren_cnt;
    tick();
    w1 = wen_cnt;
    repeat (19) tick();
    chk("hold_no_ren", 33'(ren_cnt - r0), 33'd0);
    chk("hold_no_wen", 33'(wen_cnt - w1), 33'd0);
    nf_force = 1'b0;
    wait_frame();

    for (int it = 0; it < 8; it++) begin
      nf_rand = it[0];
      slow = 1'($urandom_range(1));
      n = $urandom_range(9);
      k = (it == 3 || it == 6) ? n / 2 : n;
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom);
      wreg(BASE + 16'd1, 16'(n));
      push_samples(k);
      model_frame(n, k);
      trig();
      wreg(BASE + 16'd1, 16'($urandom_range(255)));
      wait_frame();
    end
    nf_rand = 1'b0;
    slow = 1'b0;
    repeat (3) tick();
    rd(BASE + 16'd2, 16'(ev_model), "random_evcnt");

    slow = 1'b1;
    wreg(BASE + 16'd1, 16'd8);
    for (int i = 0; i < 8; i++) smp[i] = 16'($urandom);
    push_samples(8);
    model_frame(8, 8);
    r0 = ren_cnt;
    trig();
    bus_q = {1'b0, BASE + 16'd4, 16'h0000};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(obus[2:0] == 3'd2 && ren_cnt >= r0 + 2) && t < 500);
    chk("reach_read", {32'b0, (t < 500)}, 33'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    src.delete();
    pend_src.delete();
    ev_model = 0;
    slow = 1'b0;
    @(negedge clk);
    chk("midrst_status", {17'b0, obus}, 33'd0);
    chk("midrst_out_wen", {32'b0, out_wen}, 33'd0);
    rd(BASE + 16'd2, 16'h0000, "midrst_evcnt");
    rd(BASE + 16'd0, 16'h0000, "midrst_ctrl");
    rd(BASE + 16'd1, 16'h0008, "midrst_nsamp");

    wreg(BASE, 16'h0001);
    wreg(BASE + 16'd1, 16'd0);
    exp_q.push_back(33'h1_A500_0000);
    exp_q.push_back(33'h0_5A00_0000);
    ev_model = 1;
    r0 = ren_cnt;
    trig();
    wait_frame();
    chk("nsamp0_no_reads", 33'(ren_cnt - r0), 33'd0);
    rd(BASE + 16'd2, 16'h0001, "nsamp0_evcnt");

    repeat (5) tick();
    chk("leftover_words", 33'(exp_q.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
